wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). MDU results are buffered in a small FIFO and granted when the pipeline is not writing. A starvation counter forces an MDU grant by stalling the pipeline. The block drives the 5-bit write-address/data select and a registered write strobe to the register file.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive denied cycles before a forced MDU grant (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline writeback request
- pipe_waddr  in  ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline write data
- mdu_valid  in  1  MDU result valid
- mdu_waddr  in  ADDR_W  MDU destination register
- mdu_wdata  in  DATA_W  MDU result
- mdu_ready  out  1  FIFO can accept; equals (count < DEPTH) from registered count
- rf_we  out  1  registered register-file write enable
- rf_waddr  out  ADDR_W  registered write address
- rf_wdata  out  DATA_W  registered write data
- rf_src  out  1  registered source of current write: 0 pipeline, 1 MDU
- stall_pipe  out  1  registered; pipeline must hold its writeback this cycle
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Enqueue: mdu_valid && mdu_ready pushes {mdu_waddr, mdu_wdata} at FIFO tail. mdu_valid with mdu_ready=0 is a protocol error; MDU holds its result.
- Grant decision each cycle, in priority order:
  - stall_pipe=1 and FIFO non-empty: grant FIFO head (force). pipe_we is ignored; the pipeline re-presents it next cycle.
  - pipe_we=1 and stall_pipe=0: grant pipeline.
  - Otherwise, if the FIFO is non-empty: grant FIFO head.
  - Otherwise: idle.
- A FIFO grant pops the head.
- Writes to address 0 are suppressed: rf_we=0, but a FIFO entry is still popped.
- Starvation counter:
  - Increments on each cycle the FIFO is non-empty and not granted.
  - Clears on any FIFO grant, or when the FIFO becomes empty.
  - Saturates at STARVE_MAX.
- stall_pipe is registered. It is set next cycle when the counter reaches STARVE_MAX in the current cycle and the FIFO stays non-empty. It is high for exactly one cycle per forced grant.
- Simultaneous push and pop are allowed: occupancy is unchanged.
- When full, no push occurs even if a pop happens in the same cycle, because mdu_ready is based on the registered count.
- No address comparison is done between sources. Ordering of dependent writes belongs to issue logic.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, stall_pipe=0, fifo_count=0, mdu_ready=1 (the cycle after rst deasserts). FIFO pointers and starvation counter are 0.
- rst asserted mid-operation discards all buffered MDU results. No write is issued for them.
- Pipeline write latency: pipe_we in cycle N appears on rf_* in cycle N+1.
- MDU write latency, minimum: push in cycle N, grant at the earliest in cycle N+1, rf_* in cycle N+2.
- Worst-case MDU head wait: STARVE_MAX denied cycles, then 1 stall cycle.
- Sustained throughput: one register-file write per cycle.

## Configuration
- WB_ARB_BYPASS_EN defined:
  - Conditions: FIFO empty, mdu_valid=1, pipe_we=0, stall_pipe=0.
  - The MDU result is granted directly without entering the FIFO, and is still acknowledged by mdu_ready. rf_* update in cycle N+1.
- Undefined: all MDU results pass through the FIFO. Minimum latency is 2 cycles.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> rf_we=0, stall_pipe=0, fifo_count=0, mdu_ready=1.
- Pipeline only: pipe_we=1, waddr=5'd8, wdata=32'h1234 in cycle N -> rf_we=1, rf_waddr=8, rf_src=0 in cycle N+1. Repeat with waddr=0 -> rf_we=0.
- MDU idle port: single MDU push, waddr=5'd3, wdata=32'hCAFE, pipe_we=0 -> rf_src=1 write at N+2, or N+1 with WB_ARB_BYPASS_EN.
- Full FIFO: push 2 MDU results with pipe_we held 1 -> fifo_count=2, mdu_ready=0. A third mdu_valid is not accepted.
- Starvation: STARVE_MAX=4, FIFO holds 1 entry, pipe_we=1 continuously -> stall_pipe=1 for one cycle after 4 denied cycles, and the MDU head is written that cycle+1. Counter clears.
- Reset mid-operation: FIFO holding 2 entries, assert rst 1 cycle -> no MDU write ever appears, fifo_count=0.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundles the register-file write-port request, MDU and writeback signals.
// master: pipeline/MDU side; slave: the arbiter.
interface wb_port_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_waddr;
  logic [DATA_W-1:0] mdu_wdata;
  logic              mdu_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_src;
  logic              stall_pipe;
  logic [CntW-1:0]   fifo_count;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, mdu_valid, mdu_waddr, mdu_wdata,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_pipe, fifo_count
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, mdu_valid, mdu_waddr, mdu_wdata,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_pipe, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. FIFO-buffered MDU results,
// with starvation-forced MDU grants. Define WB_ARB_BYPASS_EN to let MDU results skip the FIFO.
module wb_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(DEPTH) + 1;
  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  localparam logic [CntW-1:0]    DepthC     = CntW'(DEPTH);
  localparam logic [StarveW-1:0] StarveMaxC = StarveW'(STARVE_MAX);

  // FIFO storage; not reset, validity is tracked by count_q
  logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               stall_q, stall_d;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              rf_src_q;

  logic              fifo_empty, mdu_ready;
  logic              grant_fifo, grant_pipe, bypass, any_grant;
  logic              push, pop;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_src;

  always_comb begin
    fifo_empty = (count_q == '0);
    mdu_ready  = (count_q < DepthC);

    bypass = 1'b0;
`ifdef WB_ARB_BYPASS_EN
    bypass = fifo_empty && bus.mdu_valid && !bus.pipe_we && !stall_q;
`endif

    grant_fifo = 1'b0;
    grant_pipe = 1'b0;
    if (stall_q && !fifo_empty) begin
      grant_fifo = 1'b1;
    end else if (bus.pipe_we && !stall_q) begin
      grant_pipe = 1'b1;
    end else if (!fifo_empty) begin
      grant_fifo = 1'b1;
    end
    any_grant = grant_fifo || grant_pipe || bypass;

    push = bus.mdu_valid && mdu_ready && !bypass;
    pop  = grant_fifo;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    // Counts cycles the head waits while entries are present; saturates at the limit
    starve_d = starve_q;
    if (grant_fifo || fifo_empty || (count_d == '0)) begin
      starve_d = '0;
    end else if (starve_q != StarveMaxC) begin
      starve_d = starve_q + StarveW'(1);
    end
    stall_d = (starve_d == StarveMaxC) && (count_d != '0);

    sel_addr = bus.pipe_waddr;
    sel_data = bus.pipe_wdata;
    sel_src  = 1'b0;
    if (grant_fifo) begin
      sel_addr = addr_mem_q[rd_ptr_q];
      sel_data = data_mem_q[rd_ptr_q];
      sel_src  = 1'b1;
    end else if (bypass) begin
      sel_addr = bus.mdu_waddr;
      sel_data = bus.mdu_wdata;
      sel_src  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.mdu_waddr;
      data_mem_q[wr_ptr_q] <= bus.mdu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      // r0 is hardwired: the slot is consumed but no write is issued
      rf_we_q <= any_grant && (sel_addr != '0);
      if (any_grant) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
        rf_src_q   <= sel_src;
      end
    end
  end

  assign bus.mdu_ready  = mdu_ready;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.rf_src     = rf_src_q;
  assign bus.stall_pipe = stall_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter (default parameters).
module tb_wb_port_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_we    = 1'b0;
    bus.pipe_waddr = '0;
    bus.pipe_wdata = '0;
    bus.mdu_valid  = 1'b0;
    bus.mdu_waddr  = '0;
    bus.mdu_wdata  = '0;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.pipe_we    = we;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = v;
    bus.mdu_waddr = a;
    bus.mdu_wdata = d;
  endtask

  task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d,
                           input logic src);
    check({tag, "_we"}, 64'(bus.rf_we), 64'd1);
    check({tag, "_addr"}, 64'(bus.rf_waddr), 64'(a));
    check({tag, "_data"}, 64'(bus.rf_wdata), 64'(d));
    check({tag, "_src"}, 64'(bus.rf_src), 64'(src));
  endtask

  initial begin
    idle();
    // Reset held 3 cycles with random inputs
    for (int i = 0; i < 3; i++) begin
      pipe(1'($urandom), 5'($urandom), $urandom);
      mdu(1'($urandom), 5'($urandom), $urandom);
      step();
    end
    rst = 1'b0;
    idle();
    check("rst_we", 64'(bus.rf_we), 64'd0);
    check("rst_addr", 64'(bus.rf_waddr), 64'd0);
    check("rst_src", 64'(bus.rf_src), 64'd0);
    check("rst_stall", 64'(bus.stall_pipe), 64'd0);
    check("rst_count", 64'(bus.fifo_count), 64'd0);
    check("rst_ready", 64'(bus.mdu_ready), 64'd1);

    // Pipeline only, then r0 suppression, then idle
    pipe(1'b1, 5'd8, 32'h1234);
    step();
    expect_wr("pipe", 5'd8, 32'h1234, 1'b0);
    pipe(1'b1, 5'd0, 32'h5555);
    step();
    check("pipe_r0_we", 64'(bus.rf_we), 64'd0);
    idle();
    step();
    check("idle_we", 64'(bus.rf_we), 64'd0);

    // Single MDU result on an idle port
    mdu(1'b1, 5'd3, 32'hCAFE);
    step();
    idle();
`ifdef WB_ARB_BYPASS_EN
    expect_wr("mdu_byp", 5'd3, 32'hCAFE, 1'b1);
    check("mdu_byp_cnt", 64'(bus.fifo_count), 64'd0);
    step();
    check("mdu_byp_after", 64'(bus.rf_we), 64'd0);
`else
    check("mdu_n1_we", 64'(bus.rf_we), 64'd0);
    check("mdu_n1_cnt", 64'(bus.fifo_count), 64'd1);
    step();
    expect_wr("mdu_n2", 5'd3, 32'hCAFE, 1'b1);
    check("mdu_n2_cnt", 64'(bus.fifo_count), 64'd0);
`endif

    // Full FIFO while pipeline holds the port
    pipe(1'b1, 5'd9, 32'h9);
    mdu(1'b1, 5'd4, 32'hA);
    step();
    mdu(1'b1, 5'd5, 32'hB);
    step();
    check("full_cnt", 64'(bus.fifo_count), 64'd2);
    check("full_ready", 64'(bus.mdu_ready), 64'd0);
    expect_wr("full_pipe", 5'd9, 32'h9, 1'b0);
    mdu(1'b1, 5'd6, 32'hC);
    step();
    check("full_third_cnt", 64'(bus.fifo_count), 64'd2);
    idle();
    step();
    expect_wr("drain1", 5'd4, 32'hA, 1'b1);
    check("drain1_cnt", 64'(bus.fifo_count), 64'd1);
    check("drain1_stall", 64'(bus.stall_pipe), 64'd0);
    step();
    expect_wr("drain2", 5'd5, 32'hB, 1'b1);
    check("drain2_cnt", 64'(bus.fifo_count), 64'd0);
    step();
    check("drain_done_we", 64'(bus.rf_we), 64'd0);

    // Starvation: one entry, pipeline writing continuously
    pipe(1'b1, 5'd10, 32'h10);
    mdu(1'b1, 5'd7, 32'h77);
    step();
    mdu(1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("starve_c%0d_stall", k), 64'(bus.stall_pipe), 64'd0);
      expect_wr($sformatf("starve_c%0d", k), 5'd10, 32'h10, 1'b0);
      step();
    end
    check("starve_stall", 64'(bus.stall_pipe), 64'd1);
    step();
    expect_wr("forced", 5'd7, 32'h77, 1'b1);
    check("forced_stall", 64'(bus.stall_pipe), 64'd0);
    check("forced_cnt", 64'(bus.fifo_count), 64'd0);
    step();
    expect_wr("resume", 5'd10, 32'h10, 1'b0);
    check("resume_stall", 64'(bus.stall_pipe), 64'd0);

    // MDU result to r0 is consumed without a write
    idle();
    mdu(1'b1, 5'd0, 32'hDEAD);
    step();
    idle();
    step();
    check("mdu_r0_we", 64'(bus.rf_we), 64'd0);
    check("mdu_r0_cnt", 64'(bus.fifo_count), 64'd0);

    // Back-to-back MDU pushes with pops in the same cycle
    mdu(1'b1, 5'd11, 32'h111);
    step();
    mdu(1'b1, 5'd12, 32'h222);
`ifdef WB_ARB_BYPASS_EN
    expect_wr("pp1", 5'd11, 32'h111, 1'b1);
    step();
    expect_wr("pp2", 5'd12, 32'h222, 1'b1);
    check("pp2_cnt", 64'(bus.fifo_count), 64'd0);
    idle();
    step();
    check("pp3_we", 64'(bus.rf_we), 64'd0);
`else
    check("pp1_cnt", 64'(bus.fifo_count), 64'd1);
    step();
    expect_wr("pp2", 5'd11, 32'h111, 1'b1);
    check("pp2_cnt", 64'(bus.fifo_count), 64'd1);
    idle();
    step();
    expect_wr("pp3", 5'd12, 32'h222, 1'b1);
    check("pp3_cnt", 64'(bus.fifo_count), 64'd0);
`endif
    step();

    // Reset mid-operation discards buffered results
    pipe(1'b1, 5'd13, 32'h13);
    mdu(1'b1, 5'd14, 32'h14);
    step();
    mdu(1'b1, 5'd15, 32'h15);
    step();
    check("mid_cnt_pre", 64'(bus.fifo_count), 64'd2);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_cnt", 64'(bus.fifo_count), 64'd0);
    check("mid_ready", 64'(bus.mdu_ready), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("mid_nowr%0d", k), 64'(bus.rf_we), 64'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
